// File: rtl/i8255_strobe_in_ctrl.sv
// Mode 1 strobed-input handshake for one i8255 port: STB# sync/filter, breg latch pulse, IBF/INTR.
// Optional `overrun` status output enabled by defining I8255_STB_OVERRUN_EN.
module i8255_strobe_in_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int STB_MIN_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic stb_n,
    input  logic rd_n,
    input  logic inte,
    output logic latch_en,
    output logic ibf,
`ifdef I8255_STB_OVERRUN_EN
    output logic overrun,
`endif
    output logic intr
);

    localparam logic [3:0] MIN_CNT   = 4'(STB_MIN_CYCLES);
    localparam logic [2:0] PRIME_CNT = 3'(SYNC_STAGES);

    typedef enum logic [1:0] {
        WAIT_HIGH,
        IDLE,
        FILTER,
        LATCHED
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]             count_q, count_d;
    logic [2:0]             prime_q, prime_d;
    logic                   rd_q, rd_d;
    logic                   latch_en_q, latch_en_d;
    logic                   ibf_q, ibf_d;
    logic                   intr_flag_q, intr_flag_d;

    logic s;
    logic primed;
    logic rd_fall;
    logic rd_rise;
    logic latch_issue;
    logic strobe_done;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], stb_n};
        s       = sync_q[SYNC_STAGES-1];
        rd_d    = rd_n;
        rd_fall = rd_q & ~rd_n;
        rd_rise = ~rd_q & rd_n;
        // The chain resets to 1s, so WAIT_HIGH must ignore s until real samples have flushed through.
        primed  = (prime_q == PRIME_CNT);
        prime_d = primed ? prime_q : prime_q + 3'd1;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        latch_issue = 1'b0;
        strobe_done = 1'b0;
        case (state_q)
            WAIT_HIGH: begin
                if (primed && s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!s) begin
                    count_d = 4'd1;
                    if (MIN_CNT == 4'd1) begin
                        state_d     = LATCHED;
                        latch_issue = 1'b1;
                    end else begin
                        state_d = FILTER;
                    end
                end
            end
            FILTER: begin
                if (s) begin
                    state_d = IDLE;
                    count_d = 4'd0;
                end else begin
                    count_d = count_q + 4'd1;
                    if (count_q + 4'd1 == MIN_CNT) begin
                        state_d     = LATCHED;
                        latch_issue = 1'b1;
                    end
                end
            end
            LATCHED: begin
                if (s) begin
                    state_d     = IDLE;
                    strobe_done = 1'b1;
                    count_d     = 4'd0;
                end
            end
            default: begin
                state_d = WAIT_HIGH;
                count_d = 4'd0;
            end
        endcase
    end

    // Sets are applied after clears so fresh data is never lost to a coincident CPU read.
    always_comb begin
        latch_en_d  = latch_issue;

        ibf_d = ibf_q;
        if (rd_rise) begin
            ibf_d = 1'b0;
        end
        if (latch_issue) begin
            ibf_d = 1'b1;
        end

        intr_flag_d = intr_flag_q;
        if (rd_fall) begin
            intr_flag_d = 1'b0;
        end
        if (strobe_done && ibf_q) begin
            intr_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_HIGH;
            sync_q      <= '1;
            count_q     <= 4'd0;
            prime_q     <= 3'd0;
            rd_q        <= 1'b1;
            latch_en_q  <= 1'b0;
            ibf_q       <= 1'b0;
            intr_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            count_q     <= count_d;
            prime_q     <= prime_d;
            rd_q        <= rd_d;
            latch_en_q  <= latch_en_d;
            ibf_q       <= ibf_d;
            intr_flag_q <= intr_flag_d;
        end
    end

`ifdef I8255_STB_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (rd_rise) begin
            overrun_d = 1'b0;
        end
        if (latch_issue && ibf_q) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

    assign latch_en = latch_en_q;
    assign ibf      = ibf_q;
    assign intr     = intr_flag_q & inte;

endmodule
